// File: rtl/cache_pkg.sv
// Shared definitions for the cache-to-memory arbiter: line geometry defaults,
// FSM state encoding, owner encoding and the beat address helper.
package cache_pkg;

  localparam int LINE_WORDS_DEF = 4;
  localparam int BEAT_W_DEF     = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST_I = 2'd1,
    ST_BURST_D = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Word address of a beat: line bits kept, beat index placed above the byte offset.
  function automatic logic [31:0] beat_addr(input logic [31:0] line_addr,
                                            input logic [31:0] beat,
                                            input int          beat_w);
    logic [31:0] mask;
    mask = (32'd1 << (beat_w + 2)) - 32'd1;
    return (line_addr & ~mask) | (beat << 2);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. Holds last_grant; on a tie the side that
// was not granted last time wins.
module rr_arb2
  import cache_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_i,
  input  logic req_d,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_owner
);

  owner_e last_q;
  owner_e pick;

  always_comb begin
    pick = OWN_I;
    if (req_i && req_d) begin
      pick = (last_q == OWN_D) ? OWN_I : OWN_D;
    end else if (req_d) begin
      pick = OWN_D;
    end
  end

  assign gnt_valid = req_i | req_d;
  assign gnt_owner = pick;

  // Reset value makes the icache win the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= OWN_D;
    end else if (take && gnt_valid) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one word-wide memory port between icache refills and dcache
// refills/write-backs, running each granted line as a LINE_WORDS-beat burst.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_rvalid,
  output logic [BEAT_W-1:0] i_beat,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [BEAT_W-1:0] d_beat,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  arb_state_e        state;
  owner_e            owner;
  logic [BEAT_W-1:0] beat;
  logic              we_q;
  logic [31:0]       line_q;

  logic   gnt_valid;
  logic   gnt_raw;
  owner_e gnt_own;
  logic   burst_i;
  logic   burst_d;
  logic   bursting;

  rr_arb2 u_rr_arb2 (
    .clock     (clock),
    .reset     (reset),
    .req_i     (i_req),
    .req_d     (d_req),
    .take      (state == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_raw)
  );

  assign gnt_own = owner_e'(gnt_raw);

  // Handshake: a beat transfers on any cycle with mem_en && mem_ready; until it
  // does, mem_addr, mem_we and mem_wdata are held unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      owner  <= OWN_I;
      beat   <= '0;
      we_q   <= 1'b0;
      line_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner  <= gnt_own;
            beat   <= '0;
            we_q   <= (gnt_own == OWN_D) ? d_we : 1'b0;
            line_q <= beat_addr((gnt_own == OWN_D) ? d_addr : i_addr, 32'd0, BEAT_W);
            state  <= (gnt_own == OWN_D) ? ST_BURST_D : ST_BURST_I;
          end
        end
        ST_BURST_I, ST_BURST_D: begin
          if (mem_ready) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign burst_i  = (state == ST_BURST_I);
  assign burst_d  = (state == ST_BURST_D);
  assign bursting = burst_i | burst_d;

  // Everything below decodes registered state; non-owner outputs stay at zero.
  always_comb begin
    mem_en    = bursting;
    mem_we    = burst_d & we_q;
    mem_addr  = bursting ? beat_addr(line_q, 32'(beat), BEAT_W) : 32'd0;
    mem_wdata = (burst_d && we_q) ? d_wdata : 32'd0;

    i_rvalid  = burst_i & mem_ready;
    i_rdata   = burst_i ? mem_rdata : 32'd0;
    i_beat    = burst_i ? beat : '0;
    i_ack     = (state == ST_DONE) && (owner == OWN_I);

    d_rvalid  = burst_d & ~we_q & mem_ready;
    d_rdata   = (burst_d && !we_q) ? mem_rdata : 32'd0;
    d_beat    = burst_d ? beat : '0;
    d_ack     = (state == ST_DONE) && (owner == OWN_D);

    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a vector table for plain bursts plus
// hand-written sequences for stalls, reset mid-burst and arbitration order.
module tb_cache_mem_arbiter;

  localparam int          LINE_WORDS = 4;
  localparam int          BEAT_W     = 2;
  localparam logic [31:0] MEM_KEY    = 32'hC0DE_0000;

  logic              clock;
  logic              reset;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_rvalid;
  logic [BEAT_W-1:0] i_beat;
  logic [31:0]       i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [BEAT_W-1:0] d_beat;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic [1:0]        dbg_state;

  logic [31:0] wdata_base;
  int          n_cmp;
  int          n_bad;

  cache_mem_arbiter #(.LINE_WORDS(LINE_WORDS), .BEAT_W(BEAT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rvalid  (i_rvalid),
    .i_beat    (i_beat),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_beat    (d_beat),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Memory returns a fixed function of the address; the dcache drives its
  // write word from the beat index it is shown.
  assign mem_rdata = mem_addr ^ MEM_KEY;
  assign d_wdata   = wdata_base + {30'd0, d_beat};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ma;
    logic        en, mw;
    logic [31:0] wd;
    logic        irv, ia, drv, da, bz;
    logic [1:0]  ib, db;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic ir, input logic dr, input logic dw,
                              input logic [31:0] ma, input logic en, input logic mw,
                              input logic [31:0] wd, input logic irv, input logic ia,
                              input logic drv, input logic da, input logic bz,
                              input logic [1:0] ib, input logic [1:0] db);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ma = ma; v.en = en; v.mw = mw; v.wd = wd;
    v.irv = irv; v.ia = ia; v.drv = drv; v.da = da; v.bz = bz; v.ib = ib; v.db = db;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Entered at the start of the first burst cycle; returns at the sample
  // point of the IDLE cycle that follows the ack.
  task automatic check_burst(input logic own_d, input logic we, input logic [31:0] line,
                             input int stall_beat, input int stall_len, input int drop_beat);
    logic [31:0] ea;
    logic [31:0] ew;
    int          pulses;
    logic        rd;
    pulses = 0;
    rd     = !(own_d && we);
    for (int b = 0; b < LINE_WORDS; b++) begin
      ea = (line & ~32'hF) | (32'(b) << 2);
      ew = (own_d && we) ? wdata_base + 32'(b) : 32'd0;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          mem_ready = 1'b0;
          @(negedge clock);
          if (i_rvalid || d_rvalid) pulses++;
          chk("stall_mem_en", 32'(mem_en), 32'd1);
          chk("stall_mem_addr", mem_addr, ea);
          chk("stall_mem_wdata", mem_wdata, ew);
          chk("stall_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
          chk("stall_beat", own_d ? 32'(d_beat) : 32'(i_beat), 32'(b));
          next_cycle();
        end
      end
      mem_ready = 1'b1;
      @(negedge clock);
      if (i_rvalid || d_rvalid) pulses++;
      chk("beat_mem_en", 32'(mem_en), 32'd1);
      chk("beat_mem_we", 32'(mem_we), 32'(own_d && we));
      chk("beat_mem_addr", mem_addr, ea);
      chk("beat_mem_wdata", mem_wdata, ew);
      chk("beat_i_rvalid", 32'(i_rvalid), 32'(!own_d));
      chk("beat_d_rvalid", 32'(d_rvalid), 32'(own_d && !we));
      if (rd) chk("beat_rdata", own_d ? d_rdata : i_rdata, ea ^ MEM_KEY);
      chk("beat_own_idx", own_d ? 32'(d_beat) : 32'(i_beat), 32'(b));
      chk("beat_other_idx", own_d ? 32'(i_beat) : 32'(d_beat), 32'd0);
      chk("beat_acks", 32'({i_ack, d_ack}), 32'd0);
      if (b == drop_beat) begin
        if (own_d) d_req = 1'b0;
        else       i_req = 1'b0;
      end
      next_cycle();
    end
    @(negedge clock);
    chk("done_own_ack", own_d ? 32'(d_ack) : 32'(i_ack), 32'd1);
    chk("done_other_ack", own_d ? 32'(i_ack) : 32'(d_ack), 32'd0);
    chk("done_mem_en", 32'(mem_en), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("rvalid_count", 32'(pulses), rd ? 32'(LINE_WORDS) : 32'd0);
    if (own_d) d_req = 1'b0;
    else       i_req = 1'b0;
    next_cycle();
    @(negedge clock);
    chk("idle_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    wdata_base = 32'hA0;
    reset      = 1'b1;
    i_req      = 1'b0;
    i_addr     = 32'd0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = 32'd0;
    mem_ready  = 1'b1;

    // icache read of line 0x100, then dcache write-back of line 0x200.
    vecs[0]  = mk(1, 0, 0, 32'h000, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h100, 1, 0, 32'h00, 1, 0, 0, 0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 32'h104, 1, 0, 32'h00, 1, 0, 0, 0, 1, 1, 0);
    vecs[3]  = mk(1, 0, 0, 32'h108, 1, 0, 32'h00, 1, 0, 0, 0, 1, 2, 0);
    vecs[4]  = mk(1, 0, 0, 32'h10C, 1, 0, 32'h00, 1, 0, 0, 0, 1, 3, 0);
    vecs[5]  = mk(1, 0, 0, 32'h000, 0, 0, 32'h00, 0, 1, 0, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h000, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 32'h000, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 1, 32'h200, 1, 1, 32'hA0, 0, 0, 0, 0, 1, 0, 0);
    vecs[9]  = mk(0, 1, 1, 32'h204, 1, 1, 32'hA1, 0, 0, 0, 0, 1, 0, 1);
    vecs[10] = mk(0, 1, 1, 32'h208, 1, 1, 32'hA2, 0, 0, 0, 0, 1, 0, 2);
    vecs[11] = mk(0, 1, 1, 32'h20C, 1, 1, 32'hA3, 0, 0, 0, 0, 1, 0, 3);
    vecs[12] = mk(0, 1, 1, 32'h000, 0, 0, 32'h00, 0, 0, 0, 1, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 32'h000, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0);

    // Outputs while reset is held.
    @(negedge clock);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'd0);
    chk("rst_rvalids", 32'({i_rvalid, d_rvalid}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    next_cycle();
    reset = 1'b0;

    i_addr = 32'h0000_0104;
    d_addr = 32'h0000_0200;
    for (int k = 0; k < 14; k++) begin
      i_req = vecs[k].ir;
      d_req = vecs[k].dr;
      d_we  = vecs[k].dw;
      @(negedge clock);
      chk($sformatf("v%0d_mem_en", k), 32'(mem_en), 32'(vecs[k].en));
      chk($sformatf("v%0d_mem_we", k), 32'(mem_we), 32'(vecs[k].mw));
      chk($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].ma);
      chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].wd);
      chk($sformatf("v%0d_i_rvalid", k), 32'(i_rvalid), 32'(vecs[k].irv));
      chk($sformatf("v%0d_i_ack", k), 32'(i_ack), 32'(vecs[k].ia));
      chk($sformatf("v%0d_d_rvalid", k), 32'(d_rvalid), 32'(vecs[k].drv));
      chk($sformatf("v%0d_d_ack", k), 32'(d_ack), 32'(vecs[k].da));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].bz));
      chk($sformatf("v%0d_i_beat", k), 32'(i_beat), 32'(vecs[k].ib));
      chk($sformatf("v%0d_d_beat", k), 32'(d_beat), 32'(vecs[k].db));
      if (vecs[k].irv) chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].ma ^ MEM_KEY);
      next_cycle();
    end

    // icache read with memory stalled for 3 cycles on beat 2.
    i_req  = 1'b1;
    i_addr = 32'h0000_0344;
    next_cycle();
    check_burst(1'b0, 1'b0, 32'h340, 2, 3, -1);
    next_cycle();

    // Reset part-way through beat 1 of a dcache write-back.
    d_req  = 1'b1;
    d_we   = 1'b1;
    d_addr = 32'h0000_0280;
    next_cycle();
    @(negedge clock);
    chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
    next_cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
    chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_d_ack", 32'(d_ack), 32'd0);
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clock);
    chk("rst_hold_d_ack", 32'(d_ack), 32'd0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk($sformatf("post_rst_busy%0d", c), 32'(busy), 32'd0);
      chk($sformatf("post_rst_d_ack%0d", c), 32'(d_ack), 32'd0);
      next_cycle();
    end

    // First tie after reset goes to the icache, then the dcache.
    i_req  = 1'b1;
    i_addr = 32'h0000_030C;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0400;
    next_cycle();
    check_burst(1'b0, 1'b0, 32'h300, -1, 0, -1);
    next_cycle();
    check_burst(1'b1, 1'b0, 32'h400, -1, 0, -1);
    next_cycle();

    // dcache drops its request mid-burst while the icache waits.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0500;
    next_cycle();
    i_req  = 1'b1;
    i_addr = 32'h0000_0600;
    check_burst(1'b1, 1'b0, 32'h500, -1, 0, 1);
    next_cycle();
    check_burst(1'b0, 1'b0, 32'h600, -1, 0, -1);
    next_cycle();

    // icache was granted last, so this tie goes to the dcache first.
    i_req  = 1'b1;
    i_addr = 32'h0000_0700;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0780;
    next_cycle();
    check_burst(1'b1, 1'b0, 32'h780, -1, 0, -1);
    next_cycle();
    check_burst(1'b0, 1'b0, 32'h700, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
